// File: rtl/sdith_gf_pkg.sv
// -----------------------------------------------------------------------------
// sdith_gf_pkg
// Shared types and helpers for the SDitH GF(2^16) datapath.
//   GF(2^16) = GF(256)[X] / (X^2 + X + SDITH_IRRED_CST_GF2P16),
//   GF(256)  = GF(2)[x]  / (x^8 + x^4 + x^3 + x + 1).
// An element is packed {hi byte, lo byte} = hi*X + lo.
// -----------------------------------------------------------------------------
package sdith_gf_pkg;

    typedef logic [15:0] gf2p16_t;

    localparam logic [7:0] SDITH_IRRED_CST_GF2P16 = 8'h20;
    // Low byte of the GF(256) modulus, folded back in when x^8 is shifted out.
    localparam logic [7:0] GF256_REDUCE = 8'h1B;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        FEED,
        DRAIN,
        DONE
    } ip_state_t;

    // Shift-and-add GF(256) multiply, reducing a after every shift.
    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF256_REDUCE : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf2p16_inner_product_if.sv
// -----------------------------------------------------------------------------
// gf2p16_inner_product_if
// Run-control and operand-stream bundle of the inner-product engine.
//   i_start/i_len      : run start pulse and pair count
//   i_valid/i_x/i_y    : operand pair stream, accepted on i_valid & o_ready
//   o_ready/o_busy     : engine is accepting pairs / engine is not idle
//   o_o/o_done         : accumulated result and its one-cycle done pulse
// master = the client feeding pairs, slave = the engine.
// -----------------------------------------------------------------------------
interface gf2p16_inner_product_if #(
    parameter int LEN_W = 16
) ();
    import sdith_gf_pkg::*;

    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_valid;
    gf2p16_t          i_x;
    gf2p16_t          i_y;
    logic             o_ready;
    logic             o_busy;
    gf2p16_t          o_o;
    logic             o_done;

    modport master (
        output i_start, i_len, i_valid, i_x, i_y,
        input  o_ready, o_busy, o_o, o_done
    );

    modport slave (
        input  i_start, i_len, i_valid, i_x, i_y,
        output o_ready, o_busy, o_o, o_done
    );

endinterface

// File: rtl/gf_mul_16.sv
// -----------------------------------------------------------------------------
// gf_mul_16
// Pipelined GF(2^16) multiplier, o_o = i_a * i_b.
// Start-to-done latency is 1 + REG_IN + REG_OUT cycles (3 with defaults).
//   i_clk      : clock
//   i_start    : i_a/i_b are valid this cycle
//   i_a, i_b   : operands, packed {hi, lo}
//   o_done     : o_o holds the product of the matching i_start
//   o_o        : product
// Karatsuba over GF(256): with X^2 = X + c,
//   hi = (a1+a0)(b1+b0) + a0*b0,  lo = a0*b0 + c*a1*b1.
// -----------------------------------------------------------------------------
module gf_mul_16
    import sdith_gf_pkg::*;
#(
    parameter bit REG_IN  = 1'b1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic    i_clk,
    input  logic    i_start,
    input  gf2p16_t i_a,
    input  gf2p16_t i_b,
    output logic    o_done,
    output gf2p16_t o_o
);

    gf2p16_t    a_s, b_s;
    logic       v_s;
    logic [7:0] p_hh_d, p_ll_d, p_mid_d;
    logic [7:0] p_hh_q, p_ll_q, p_mid_q;
    logic       v_mid_q;
    gf2p16_t    res_d;

    // NOTE: the pipeline has no reset: the owner discards whatever comes out
    // after reset, so clearing these flops would buy nothing.
    if (REG_IN) begin : g_in_reg
        gf2p16_t a_q, b_q;
        logic    v_q;
        always_ff @(posedge i_clk) begin
            a_q <= i_a;
            b_q <= i_b;
            v_q <= i_start;
        end
        assign a_s = a_q;
        assign b_s = b_q;
        assign v_s = v_q;
    end else begin : g_in_comb
        assign a_s = i_a;
        assign b_s = i_b;
        assign v_s = i_start;
    end

    always_comb begin
        p_hh_d  = gf256_mul(a_s[15:8], b_s[15:8]);
        p_ll_d  = gf256_mul(a_s[7:0],  b_s[7:0]);
        p_mid_d = gf256_mul(a_s[15:8] ^ a_s[7:0], b_s[15:8] ^ b_s[7:0]);
    end

    always_ff @(posedge i_clk) begin
        p_hh_q  <= p_hh_d;
        p_ll_q  <= p_ll_d;
        p_mid_q <= p_mid_d;
        v_mid_q <= v_s;
    end

    always_comb begin
        res_d = {p_mid_q ^ p_ll_q, p_ll_q ^ gf256_mul(SDITH_IRRED_CST_GF2P16, p_hh_q)};
    end

    if (REG_OUT) begin : g_out_reg
        gf2p16_t res_q;
        logic    done_q;
        always_ff @(posedge i_clk) begin
            res_q  <= res_d;
            done_q <= v_mid_q;
        end
        assign o_o    = res_q;
        assign o_done = done_q;
    end else begin : g_out_comb
        assign o_o    = res_d;
        assign o_done = v_mid_q;
    end

endmodule

// File: rtl/gf2p16_inner_product.sv
// -----------------------------------------------------------------------------
// gf2p16_inner_product
// Streaming GF(2^16) inner product: o_o = XOR over k of x_k * y_k for a run of
// i_len pairs. Each accepted pair starts the gf_mul_16 instance; each product
// it returns is XOR-accumulated. After reset the engine sits in FLUSH for
// MUL_LAT+1 cycles so stale products from the unreset multiplier drain out.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : run control, pair stream and result (see the interface)
// All bus outputs are registered; o_done and o_o land in the cycle after DONE.
// -----------------------------------------------------------------------------
module gf2p16_inner_product
    import sdith_gf_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int MUL_LAT = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    gf2p16_inner_product_if.slave bus
);

    localparam int FLUSH_W = $clog2(MUL_LAT + 2);

    ip_state_t        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] received_q, received_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    gf2p16_t          acc_q, acc_d;
    logic             o_ready_q, o_ready_d;
    logic             o_busy_q, o_busy_d;
    logic             o_done_q, o_done_d;
    gf2p16_t          o_o_q, o_o_d;

    logic    mul_start;
    logic    mul_done;
    gf2p16_t mul_o;

    // o_ready_q is only high in FEED, so this is the accept strobe.
    assign mul_start = bus.i_valid & o_ready_q;

    gf_mul_16 #(
        .REG_IN  (1'b1),
        .REG_OUT (1'b1)
    ) u_mul (
        .i_clk   (i_clk),
        .i_start (mul_start),
        .i_a     (bus.i_x),
        .i_b     (bus.i_y),
        .o_done  (mul_done),
        .o_o     (mul_o)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        received_d  = received_q;
        flush_cnt_d = flush_cnt_q;
        acc_d       = acc_q;
        o_o_d       = o_o_q;

        case (state_q)
            FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(MUL_LAT)) state_d = IDLE;
                else                                  flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
            IDLE: begin
                if (bus.i_start) begin
                    len_d      = bus.i_len;
                    acc_d      = '0;
                    issued_d   = '0;
                    received_d = '0;
                    state_d    = (bus.i_len == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                if (mul_start) begin
                    issued_d = issued_q + LEN_W'(1);
                    if (issued_q + LEN_W'(1) == len_q) state_d = DRAIN;
                end
            end
            DRAIN: ;
            DONE: begin
                o_o_d   = acc_q;
                state_d = IDLE;
            end
            default: state_d = FLUSH;
        endcase

        // Products return while still feeding, so accumulate in FEED and
        // DRAIN; the issue and receive counters are independent. The last
        // product can only arrive in DRAIN, since it trails its own accept.
        if (mul_done && (state_q == FEED || state_q == DRAIN)) begin
            acc_d      = acc_q ^ mul_o;
            received_d = received_q + LEN_W'(1);
            if (state_q == DRAIN && received_q + LEN_W'(1) == len_q) state_d = DONE;
        end

        o_ready_d = (state_d == FEED);
        o_busy_d  = (state_d != IDLE);
        o_done_d  = (state_q == DONE);
    end

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= FLUSH;
            len_q       <= '0;
            issued_q    <= '0;
            received_q  <= '0;
            flush_cnt_q <= '0;
            acc_q       <= '0;
            o_ready_q   <= 1'b0;
            o_busy_q    <= 1'b1;
            o_done_q    <= 1'b0;
            o_o_q       <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            received_q  <= received_d;
            flush_cnt_q <= flush_cnt_d;
            acc_q       <= acc_d;
            o_ready_q   <= o_ready_d;
            o_busy_q    <= o_busy_d;
            o_done_q    <= o_done_d;
            o_o_q       <= o_o_d;
        end
    end

    assign bus.o_ready = o_ready_q;
    assign bus.o_busy  = o_busy_q;
    assign bus.o_done  = o_done_q;
    assign bus.o_o     = o_o_q;

endmodule

// File: tb/tb_gf2p16_inner_product.sv
// -----------------------------------------------------------------------------
// tb_gf2p16_inner_product
// Scoreboarded bench: each run pushes {expected result, expected o_done cycle}
// computed from a plain polynomial-arithmetic model; a monitor pops and
// compares on every o_done. Inputs change and outputs are sampled on the
// falling clock edge; cyc counts rising edges.
// -----------------------------------------------------------------------------
module tb_gf2p16_inner_product;
    import sdith_gf_pkg::*;

    localparam int LEN_W   = 16;
    localparam int MUL_LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    gf2p16_inner_product_if #(.LEN_W(LEN_W)) bus ();

    gf2p16_inner_product #(
        .LEN_W   (LEN_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] vx[$];
    logic [15:0] vy[$];
    logic [15:0] hold_val = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: schoolbook polynomial products, reduced by long division.
    function automatic logic [7:0] m_gf256(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11B << (i - 8);
        return p[7:0];
    endfunction

    // (x1 X + x0)(y1 X + y0) = c2 X^2 + c1 X + c0, then X^2 = X + 0x20.
    function automatic logic [15:0] m_mul(input logic [15:0] x, input logic [15:0] y);
        logic [7:0] c2, c1, c0;
        c2 = m_gf256(x[15:8], y[15:8]);
        c1 = m_gf256(x[15:8], y[7:0]) ^ m_gf256(x[7:0], y[15:8]);
        c0 = m_gf256(x[7:0], y[7:0]);
        return {c1 ^ c2, c0 ^ m_gf256(8'h20, c2)};
    endfunction

    // Monitor: result/timing scoreboard plus the multiplier-done protocol rule.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && dut.mul_done)
                check("mul_done_in_idle_or_done", 32'(dut.state_q == IDLE || dut.state_q == DONE), 0);
            if (bus.o_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.o_done), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 32'(bus.o_o), 32'(e.res));
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || bus.o_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending_results", 32'(sb_q.size()), 0);
        check("idle_reached", 32'(bus.o_busy), 0);
        @(negedge clk);
    endtask

    // Assert reset, check it acts immediately, release, then check the flush
    // window while a stray start is offered in its first cycle.
    task automatic do_reset();
        int r;
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_o_ready", 32'(bus.o_ready), 0);
        check("rst_o_busy",  32'(bus.o_busy),  1);
        check("rst_o_done",  32'(bus.o_done),  0);
        check("rst_o_o",     32'(bus.o_o),     0);
        sb_q.delete();
        hold_val = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_len   = LEN_W'(1);
        bus.i_valid = 1'b1;
        bus.i_x     = 16'h0001;
        bus.i_y     = 16'h7777;
        for (int k = 1; k <= MUL_LAT; k++) begin
            check("flush_busy", 32'(bus.o_busy), 1);
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        check("flush_over_cycle", cyc - r, MUL_LAT + 1);
        check("flush_end_idle", 32'(bus.o_busy), 0);
        check("flush_o_o", 32'(bus.o_o), 0);
        bus.i_valid = 1'b0;
    endtask

    // One run over vx/vy. abort_after >= 0 resets the engine after that many
    // accepts instead of letting the run complete.
    task automatic run(input int len, input bit gapped, input int abort_after);
        logic [15:0] acc;
        int          idx  = 0;
        int          n    = 0;
        int          last = -1;
        int          s;
        bit          v;
        wait_idle();
        check("o_o_hold", 32'(bus.o_o), 32'(hold_val));
        acc = '0;
        for (int i = 0; i < len; i++) acc ^= m_mul(vx[i], vy[i]);

        // Start cycle, with a stray valid pair that must not be accepted.
        bus.i_start = 1'b1;
        bus.i_len   = LEN_W'(len);
        bus.i_valid = 1'b1;
        bus.i_x     = 16'($urandom);
        bus.i_y     = 16'($urandom);
        s = cyc;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_valid = 1'b0;

        if (len == 0) begin
            sb_q.push_back('{16'h0000, s + 2});
            hold_val = '0;
            bus.i_start = 1'b1;          // lands in DONE and must be ignored
            bus.i_len   = LEN_W'(5);
            @(negedge clk);
            bus.i_start = 1'b0;
            return;
        end

        while (idx < len && n < 4 * len + 20) begin
            v = gapped ? n[0] : 1'b1;
            bus.i_valid = v;
            bus.i_x     = v ? vx[idx] : 16'($urandom);
            bus.i_y     = v ? vy[idx] : 16'($urandom);
            if (v && bus.o_ready) begin
                last = cyc;
                idx++;
            end
            @(negedge clk);
            n++;
            if (abort_after >= 0 && idx == abort_after) break;
        end
        bus.i_valid = 1'b0;

        if (abort_after >= 0) begin
            check("accepts_before_abort", idx, abort_after);
            do_reset();
            return;
        end

        check("feed_complete", idx, len);
        check("ready_drop_after_last", 32'(bus.o_ready), 0);
        sb_q.push_back('{acc, last + MUL_LAT + 2});
        hold_val = acc;
    endtask

    initial begin
        int len;
        bus.i_start = 1'b0;
        bus.i_len   = '0;
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        bus.i_y     = '0;
        #2;
        do_reset();

        vx = '{16'h0100};
        vy = '{16'h0100};
        run(1, 1'b0, -1);

        vx = '{16'h0001, 16'h0001};
        vy = '{16'h1234, 16'h00FF};
        run(2, 1'b0, -1);

        vx = '{16'h0001, 16'h0000, 16'h0001};
        vy = '{16'hABCD, 16'hFFFF, 16'h0001};
        run(3, 1'b1, -1);

        run(0, 1'b0, -1);

        vx.delete();
        vy.delete();
        for (int i = 0; i < 8; i++) begin
            vx.push_back(16'($urandom));
            vy.push_back(16'($urandom));
        end
        run(8, 1'b0, 4);

        vx = '{16'h0001};
        vy = '{16'h5555};
        run(1, 1'b0, -1);

        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, 12);
            vx.delete();
            vy.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0:       vx.push_back(16'h0000);
                    1:       vx.push_back(16'h0001);
                    default: vx.push_back(16'($urandom));
                endcase
                vy.push_back(16'($urandom));
            end
            run(len, 1'($urandom_range(0, 1)), -1);
        end

        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
